// File: rtl/gspi_pkg.sv
// Shared types and framing constants for the generic SPI peripheral register block.
package gspi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } gspi_periph_state_t;

  localparam int unsigned HDR_BITS   = 16;
  localparam int unsigned WORD_BITS  = 32;
  localparam int unsigned ADDR_BITS  = 15;
  localparam int unsigned WR_BIT_POS = 0;

endpackage

// File: rtl/gspi_shift32.sv
// 32-bit shift register, LSB-first: serial data enters at the MSB and leaves at bit 0.
module gspi_shift32
  import gspi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 sin,
  input  logic [WORD_BITS-1:0] load_val,
  output logic [WORD_BITS-1:0] q
);

  // shift state: clear beats load, load beats shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {sin, q[WORD_BITS-1:1]};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/generic_spi_peripheral_regs.sv
// SPI responder exposing NUM_REGS config registers; runs on spi_clk only.
// Define GSPI_PERIPH_STATUS_EN to add read-only status words above the config bank.
module generic_spi_peripheral_regs
  import gspi_pkg::*;
#(
  parameter int unsigned          NUM_REGS      = 16,
  parameter int unsigned          NUM_STATUS    = 4,
  parameter logic [WORD_BITS-1:0] REG_RESET_VAL = 32'h0000_0000
) (
  input  logic                          spi_clk,
  input  logic                          spi_resetn,
  input  logic                          cs_b,
  input  logic                          pico,
`ifdef GSPI_PERIPH_STATUS_EN
  input  logic [NUM_STATUS*WORD_BITS-1:0] status_in,
`endif
  output logic                          poci,
  output logic [NUM_REGS*WORD_BITS-1:0] reg_out,
  output logic [NUM_REGS-1:0]           reg_wr_strb,
  output logic [15:0]                   frame_count,
  output logic                          err_truncated,
  output logic                          busy
);

  localparam logic [4:0]  HDR_LAST   = 5'(HDR_BITS - 1);
  // header bit0 sits here in the RX register just before the last header bit shifts in
  localparam int unsigned HDR_WR_POS = WORD_BITS - HDR_BITS + 1 + WR_BIT_POS;

  gspi_periph_state_t     state_r, state_next_s;
  logic [4:0]             bit_cnt_r;
  logic [ADDR_BITS-1:0]   addr_r, hdr_addr_s, lookup_addr_s;
  logic [31:0]            addr_ext_s, lookup_ext_s;
  logic                   wr_r, hdr_wr_s;
  logic                   hdr_done_s, word_done_s, frame_end_s, trunc_s, commit_s;
  logic                   load_tx_s, shift_tx_s, in_status_s;
  logic [WORD_BITS-1:0]   rx_q_s, tx_q_s, rx_word_s, rd_word_s;
  logic                   unused_s;

  assign hdr_wr_s   = rx_q_s[HDR_WR_POS];
  assign hdr_addr_s = {pico, rx_q_s[WORD_BITS-1:HDR_WR_POS+1]};
  assign rx_word_s  = {pico, rx_q_s[WORD_BITS-1:1]};
  assign addr_ext_s = {17'd0, addr_r};
  assign commit_s   = word_done_s && wr_r;
  assign trunc_s    = frame_end_s && ((state_r == HEADER) || (bit_cnt_r != 5'd0));
  assign load_tx_s  = (hdr_done_s && !hdr_wr_s) || (word_done_s && !wr_r);
  assign shift_tx_s = (state_r == DATA) && !cs_b;
  assign poci       = tx_q_s[0];
  assign unused_s   = ^{tx_q_s[WORD_BITS-1:1], rx_q_s[0]};

  gspi_shift32 u_rx (
    .clk      (spi_clk),
    .rst_n    (spi_resetn),
    .clr      (1'b0),
    .load     (1'b0),
    .shift    (!cs_b),
    .sin      (pico),
    .load_val ({WORD_BITS{1'b0}}),
    .q        (rx_q_s)
  );

  gspi_shift32 u_tx (
    .clk      (spi_clk),
    .rst_n    (spi_resetn),
    .clr      (frame_end_s),
    .load     (load_tx_s),
    .shift    (shift_tx_s),
    .sin      (1'b0),
    .load_val (rd_word_s),
    .q        (tx_q_s)
  );

  // frame sequencing: next state and per-edge events
  always_comb begin
    state_next_s = state_r;
    hdr_done_s   = 1'b0;
    word_done_s  = 1'b0;
    frame_end_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!cs_b) state_next_s = HEADER;
        else       state_next_s = IDLE;
      end
      HEADER: begin
        if (cs_b) begin
          frame_end_s  = 1'b1;
          state_next_s = IDLE;
        end else if (bit_cnt_r == HDR_LAST) begin
          hdr_done_s   = 1'b1;
          state_next_s = DATA;
        end else begin
          state_next_s = HEADER;
        end
      end
      DATA: begin
        if (cs_b) begin
          frame_end_s  = 1'b1;
          state_next_s = IDLE;
        end else begin
          word_done_s  = (bit_cnt_r == 5'd31);
          state_next_s = DATA;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // read word for the next TX load; status words are captured at the same instant
  always_comb begin
    lookup_addr_s = hdr_done_s ? hdr_addr_s : addr_r + 15'd1;
    lookup_ext_s  = {17'd0, lookup_addr_s};
    in_status_s   = (lookup_ext_s >= NUM_REGS) && (lookup_ext_s < NUM_REGS + NUM_STATUS);
    rd_word_s     = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (lookup_ext_s == k) rd_word_s = reg_out[k*WORD_BITS +: WORD_BITS];
      else                   rd_word_s = rd_word_s;
    end
    if (in_status_s) begin
`ifdef GSPI_PERIPH_STATUS_EN
      for (int unsigned s = 0; s < NUM_STATUS; s++) begin
        if (lookup_ext_s == NUM_REGS + s) rd_word_s = status_in[s*WORD_BITS +: WORD_BITS];
        else                              rd_word_s = rd_word_s;
      end
`else
      rd_word_s = '0;
`endif
    end else begin
      rd_word_s = rd_word_s;
    end
  end

  // state register
  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s != IDLE);
    end
  end

  // bit position, latched header, register bank and frame bookkeeping
  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      bit_cnt_r     <= 5'd0;
      addr_r        <= '0;
      wr_r          <= 1'b0;
      reg_out       <= {NUM_REGS{REG_RESET_VAL}};
      reg_wr_strb   <= '0;
      frame_count   <= 16'd0;
      err_truncated <= 1'b0;
    end else begin
      reg_wr_strb <= '0;
      if (frame_end_s || hdr_done_s) bit_cnt_r <= 5'd0;
      else if (!cs_b)                bit_cnt_r <= bit_cnt_r + 5'd1;
      else                           bit_cnt_r <= bit_cnt_r;
      if (hdr_done_s) begin
        wr_r   <= hdr_wr_s;
        addr_r <= hdr_addr_s;
      end else if (word_done_s) begin
        addr_r <= addr_r + 15'd1;
      end else begin
        addr_r <= addr_r;
      end
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (commit_s && (addr_ext_s == k)) begin
          reg_out[k*WORD_BITS +: WORD_BITS] <= rx_word_s;
          reg_wr_strb[k]                    <= 1'b1;
        end
      end
      if (frame_end_s) frame_count <= frame_count + 16'd1;
      if (trunc_s)     err_truncated <= 1'b1;
    end
  end

endmodule

// File: tb/tb_generic_spi_peripheral_regs.sv
// Directed self-checking bench for generic_spi_peripheral_regs (default 16 registers).
module tb_generic_spi_peripheral_regs;

  logic         spi_clk = 1'b0;
  logic         spi_resetn;
  logic         cs_b;
  logic         pico;
  logic         poci;
  logic [511:0] reg_out;
  logic [15:0]  reg_wr_strb;
  logic [15:0]  frame_count;
  logic         err_truncated;
  logic         busy;
`ifdef GSPI_PERIPH_STATUS_EN
  logic [127:0] status_in = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0]  exp_regs [16];
  logic [15:0]  strb_q [$];
  logic [15:0]  exp_fc;
  logic [127:0] rx;

  always #5 spi_clk = ~spi_clk;

  generic_spi_peripheral_regs dut (
    .spi_clk       (spi_clk),
    .spi_resetn    (spi_resetn),
    .cs_b          (cs_b),
    .pico          (pico),
`ifdef GSPI_PERIPH_STATUS_EN
    .status_in     (status_in),
`endif
    .poci          (poci),
    .reg_out       (reg_out),
    .reg_wr_strb   (reg_wr_strb),
    .frame_count   (frame_count),
    .err_truncated (err_truncated),
    .busy          (busy)
  );

  always @(negedge spi_clk) begin
    if (reg_wr_strb !== 16'h0000) strb_q.push_back(reg_wr_strb);
  end

  function automatic logic [15:0] hdr(input logic wr, input logic [14:0] a);
    return {a, wr};
  endfunction

  function automatic logic [511:0] flat_regs();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = exp_regs[k];
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bits(input logic [127:0] bits, input int n, output logic [127:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge spi_clk);
      cs_b    = 1'b0;
      pico    = bits[i];
      got[i]  = poci;
    end
  endtask

  task automatic end_frame();
    @(negedge spi_clk);
    cs_b = 1'b1;
    pico = 1'b0;
    @(negedge spi_clk);
  endtask

  task automatic send_frame(input logic [127:0] bits, input int n, output logic [127:0] got);
    strb_q.delete();
    drive_bits(bits, n, got);
    end_frame();
  endtask

  initial begin
    cs_b       = 1'b1;
    pico       = 1'b0;
    spi_resetn = 1'b0;
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    exp_fc = 16'd0;
    repeat (2) @(negedge spi_clk);
    check("rst_poci", poci, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_truncated, 1'b0);
    check("rst_fc", frame_count, 16'd0);
    check("rst_regs", reg_out, flat_regs());
    check("rst_strb", reg_wr_strb, 16'h0);
    spi_resetn = 1'b1;
    @(negedge spi_clk);

    // single write to reg 2
    send_frame({80'd0, 32'h1234_5678, hdr(1'b1, 15'd2)}, 48, rx);
    exp_regs[2] = 32'h1234_5678; exp_fc++;
    check("wr_regs", reg_out, flat_regs());
    check("wr_strb_cnt", strb_q.size(), 1);
    check("wr_strb_val", (strb_q.size() > 0) ? strb_q[0] : 16'h0, 16'h0004);
    check("wr_fc", frame_count, exp_fc);
    check("wr_err", err_truncated, 1'b0);
    check("wr_busy", busy, 1'b0);

    // read back reg 2
    send_frame({112'd0, hdr(1'b0, 15'd2)}, 48, rx);
    exp_fc++;
    check("rd_word", rx[47:16], 32'h1234_5678);
    check("rd_strb_cnt", strb_q.size(), 0);
    check("rd_fc", frame_count, exp_fc);
    check("rd_poci_idle", poci, 1'b0);

    // burst write regs 0..2
    send_frame({16'd0, 32'hCAFE_F00D, 32'h0BAD_F00D, 32'hDEAD_BEEF, hdr(1'b1, 15'd0)}, 112, rx);
    exp_regs[0] = 32'hDEAD_BEEF; exp_regs[1] = 32'h0BAD_F00D; exp_regs[2] = 32'hCAFE_F00D; exp_fc++;
    check("bwr_regs", reg_out, flat_regs());
    check("bwr_strb_cnt", strb_q.size(), 3);
    check("bwr_strb_seq", (strb_q.size() == 3) ? {strb_q[0], strb_q[1], strb_q[2]} : 48'h0,
          {16'h0001, 16'h0002, 16'h0004});
    check("bwr_fc", frame_count, exp_fc);

    // burst read regs 0..1
    send_frame({112'd0, hdr(1'b0, 15'd0)}, 80, rx);
    exp_fc++;
    check("brd_w0", rx[47:16], 32'hDEAD_BEEF);
    check("brd_w1", rx[79:48], 32'h0BAD_F00D);

    // read across address wrap 32767 -> 0
    send_frame({112'd0, hdr(1'b0, 15'h7FFF)}, 80, rx);
    exp_fc++;
    check("wrap_w0", rx[47:16], 32'h0);
    check("wrap_w1", rx[79:48], 32'hDEAD_BEEF);

    // truncated write after 20 bits
    send_frame({80'd0, 32'hFFFF_FFFF, hdr(1'b1, 15'd1)}, 20, rx);
    exp_fc++;
    check("trunc_regs", reg_out, flat_regs());
    check("trunc_strb_cnt", strb_q.size(), 0);
    check("trunc_err", err_truncated, 1'b1);
    check("trunc_fc", frame_count, exp_fc);

    // out-of-range write and read
    send_frame({80'd0, 32'h7777_7777, hdr(1'b1, 15'd21)}, 48, rx);
    exp_fc++;
    check("oor_wr_regs", reg_out, flat_regs());
    check("oor_wr_strb_cnt", strb_q.size(), 0);
    send_frame({112'd0, hdr(1'b0, 15'd21)}, 48, rx);
    exp_fc++;
    check("oor_rd_word", rx[47:16], 32'h0);
    check("oor_fc", frame_count, exp_fc);
`ifdef GSPI_PERIPH_STATUS_EN
    send_frame({112'd0, hdr(1'b0, 15'd17)}, 48, rx);
    check("status_rd_word", rx[47:16], 32'hA5A5_0001);
`endif

    // reset pulse in the middle of a write frame
    strb_q.delete();
    drive_bits({80'd0, 32'h0F0F_0F0F, hdr(1'b1, 15'd3)}, 30, rx);
    @(posedge spi_clk);
    #2;
    check("mid_busy", busy, 1'b1);
    spi_resetn = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    exp_fc = 16'd0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_err", err_truncated, 1'b0);
    check("mrst_fc", frame_count, exp_fc);
    check("mrst_regs", reg_out, flat_regs());
    check("mrst_poci", poci, 1'b0);
    @(negedge spi_clk);
    cs_b = 1'b1;
    pico = 1'b0;
    @(negedge spi_clk);
    spi_resetn = 1'b1;
    @(negedge spi_clk);

    send_frame({80'd0, 32'h55AA_33CC, hdr(1'b1, 15'd3)}, 48, rx);
    exp_regs[3] = 32'h55AA_33CC; exp_fc++;
    check("post_regs", reg_out, flat_regs());
    check("post_strb_val", (strb_q.size() == 1) ? strb_q[0] : 16'h0, 16'h0008);
    check("post_fc", frame_count, exp_fc);
    check("post_err", err_truncated, 1'b0);

    // cs_b rises on the edge that would sample data bit 31
    send_frame({80'd0, 32'h8000_0001, hdr(1'b1, 15'd4)}, 47, rx);
    exp_fc++;
    check("b31_regs", reg_out, flat_regs());
    check("b31_strb_cnt", strb_q.size(), 0);
    check("b31_err", err_truncated, 1'b1);
    check("b31_fc", frame_count, exp_fc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
